// File: rtl/seq_ctrl_param_if.sv
// Run sequencer bus: request inputs and datapath control outputs.
// master drives requests, slave is the sequencer.
interface seq_ctrl_param_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] run_len;
  logic             repeat_en;
  logic             rst;
  logic             load;
  logic             enable;
  logic             done;
  logic             busy;
  logic [CNT_W-1:0] count;

  modport master (
    output start, abort, run_len, repeat_en,
    input  rst, load, enable, done, busy, count
  );

  modport slave (
    input  start, abort, run_len, repeat_en,
    output rst, load, enable, done, busy, count
  );
endinterface

// File: rtl/seq_ctrl_param.sv
// Run sequencer: reset release, load strobe, timed enable run,
// done pulse, abort and auto-repeat.
module seq_ctrl_param #(
  parameter int CNT_W       = 4,
  parameter int LOAD_CYCLES = 1,
  parameter bit RST_IDLE    = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  seq_ctrl_param_if.slave   bus
);

  localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [LW-1:0] LC_LAST = LW'(LOAD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } st_t;

  st_t              r_state;
  st_t              w_nxt;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_p1;
  logic [LW-1:0]    r_lcnt;
  logic             w_latch;
  logic             w_cinc;

  logic r_rst, r_load, r_en, r_done, r_busy;
  logic w_rst, w_load, w_en, w_done, w_busy;

  assign w_cnt_p1 = r_cnt + 1'b1;

  // State, counters and registered outputs of the state being entered
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_lcnt  <= '0;
      r_rst   <= 1'b1;
      r_load  <= 1'b0;
      r_en    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_latch)
        r_len <= bus.run_len;
      if (w_latch)
        r_cnt <= '0;
      else if (w_cinc)
        r_cnt <= w_cnt_p1;
      if (r_state == S_LOAD && w_nxt == S_LOAD)
        r_lcnt <= r_lcnt + 1'b1;
      else
        r_lcnt <= '0;
      r_rst  <= w_rst;
      r_load <= w_load;
      r_en   <= w_en;
      r_done <= w_done;
      r_busy <= w_busy;
    end
  end

  // Next state: abort beats completion, completion beats repeat
  always_comb begin
    w_nxt   = r_state;
    w_latch = 1'b0;
    w_cinc  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_nxt   = S_LOAD;
          w_latch = 1'b1;
        end
      end
      S_LOAD: begin
        if (bus.abort)
          w_nxt = S_IDLE;
        else if (r_lcnt == LC_LAST)
          w_nxt = (r_len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        w_cinc = 1'b1;
        if (bus.abort)
          w_nxt = S_IDLE;
        else if (w_cnt_p1 == r_len)
          w_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.abort) begin
          w_nxt = S_IDLE;
        end else if (bus.repeat_en) begin
          w_nxt   = S_LOAD;
          w_latch = 1'b1;
        end else begin
          w_nxt = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Output decode of the next state, registered at the edge
  always_comb begin
    w_rst  = (w_nxt == S_IDLE) ? RST_IDLE : 1'b0;
    w_load = (w_nxt == S_LOAD);
    w_en   = (w_nxt == S_RUN);
    w_done = (w_nxt == S_DONE);
    w_busy = (w_nxt != S_IDLE);
  end

  assign bus.rst    = r_rst;
  assign bus.load   = r_load;
  assign bus.enable = r_en;
  assign bus.done   = r_done;
  assign bus.busy   = r_busy;
  assign bus.count  = r_cnt;

endmodule

// File: tb/tb_seq_ctrl_param.sv
// Bench for seq_ctrl_param: two parameterisations against a
// per-cycle plan model built from the run rules.
module tb_seq_ctrl_param;

  typedef struct packed {
    logic       rst;
    logic       load;
    logic       en;
    logic       done;
    logic       busy;
    logic [3:0] cnt;
  } ob_t;

  localparam int LCY [2] = '{1, 3};
  localparam bit RIX [2] = '{1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       s_start = 1'b0;
  logic       s_abort = 1'b0;
  logic [3:0] s_len = 4'd0;
  logic       s_rep = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  ob_t cur [2];
  ob_t plan [2][$];

  seq_ctrl_param_if #(.CNT_W(4)) if0 ();
  seq_ctrl_param_if #(.CNT_W(4)) if1 ();

  assign if0.start     = s_start;
  assign if0.abort     = s_abort;
  assign if0.run_len   = s_len;
  assign if0.repeat_en = s_rep;
  assign if1.start     = s_start;
  assign if1.abort     = s_abort;
  assign if1.run_len   = s_len;
  assign if1.repeat_en = s_rep;

  seq_ctrl_param #(
    .CNT_W(4), .LOAD_CYCLES(1), .RST_IDLE(1'b1)
  ) u_d0 (
    .clk(clk), .rstn(rstn), .bus(if0.slave)
  );

  seq_ctrl_param #(
    .CNT_W(4), .LOAD_CYCLES(3), .RST_IDLE(1'b0)
  ) u_d1 (
    .clk(clk), .rstn(rstn), .bus(if1.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all();
    ob_t o0, o1;
    o0 = '{rst: if0.rst, load: if0.load, en: if0.enable,
           done: if0.done, busy: if0.busy, cnt: if0.count};
    o1 = '{rst: if1.rst, load: if1.load, en: if1.enable,
           done: if1.done, busy: if1.busy, cnt: if1.count};
    chk("dut0_outs", 32'(o0), 32'(cur[0]));
    chk("dut1_outs", 32'(o1), 32'(cur[1]));
  endtask

  // Expected output of every cycle of one run, queued in order
  task automatic build(int i, int len);
    for (int k = 0; k < LCY[i]; k++)
      plan[i].push_back('{rst: 1'b0, load: 1'b1, en: 1'b0,
                          done: 1'b0, busy: 1'b1, cnt: 4'd0});
    for (int k = 0; k < len; k++)
      plan[i].push_back('{rst: 1'b0, load: 1'b0, en: 1'b1,
                          done: 1'b0, busy: 1'b1, cnt: 4'(k)});
    plan[i].push_back('{rst: 1'b0, load: 1'b0, en: 1'b0,
                        done: 1'b1, busy: 1'b1, cnt: 4'(len)});
  endtask

  task automatic m_edge(int i);
    ob_t idl;
    idl = '{rst: RIX[i], load: 1'b0, en: 1'b0,
            done: 1'b0, busy: 1'b0, cnt: cur[i].cnt};
    if (!cur[i].busy) begin
      if (s_start) begin
        build(i, int'(s_len));
        cur[i] = plan[i].pop_front();
      end else begin
        cur[i] = idl;
      end
    end else if (s_abort) begin
      plan[i].delete();
      if (cur[i].en)
        idl.cnt = cur[i].cnt + 4'd1;
      cur[i] = idl;
    end else if (plan[i].size() > 0) begin
      cur[i] = plan[i].pop_front();
    end else if (s_rep) begin
      build(i, int'(s_len));
      cur[i] = plan[i].pop_front();
    end else begin
      cur[i] = idl;
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      plan[i].delete();
      cur[i] = '{rst: 1'b1, load: 1'b0, en: 1'b0,
                 done: 1'b0, busy: 1'b0, cnt: 4'd0};
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rstn) begin
      m_edge(0);
      m_edge(1);
    end
    cyc++;
    @(negedge clk);
    chk_all();
  endtask

  task automatic steps(int n);
    for (int k = 0; k < n; k++)
      step();
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    chk_all();
    step();
    rstn = 1'b1;
    steps(2);

    // Basic run of length 5
    s_start = 1'b1; s_len = 4'd5;
    step();
    s_start = 1'b0;
    steps(14);

    // Zero-length run
    s_start = 1'b1; s_len = 4'd0;
    step();
    s_start = 1'b0;
    steps(8);

    // Max length with repeat, run_len changed mid-run
    s_start = 1'b1; s_len = 4'd15; s_rep = 1'b1;
    step();
    s_start = 1'b0;
    steps(5);
    s_len = 4'd2;
    steps(50);
    s_rep = 1'b0;
    steps(20);

    // Abort during the third enable cycle of a length-8 run
    s_start = 1'b1; s_len = 4'd8;
    step();
    s_start = 1'b0;
    steps(3);
    s_abort = 1'b1;
    step();
    s_abort = 1'b0;
    chk("abort_count", 32'(if0.count), 32'd3);
    chk("abort_busy", 32'(if0.busy), 32'd0);
    chk("abort_done", 32'(if0.done), 32'd0);
    chk("abort_en", 32'(if0.enable), 32'd0);
    steps(4);

    // Start pulsed while busy is ignored
    s_start = 1'b1; s_len = 4'd6;
    step();
    s_start = 1'b0;
    steps(4);
    s_start = 1'b1; s_len = 4'd1;
    step();
    s_start = 1'b0;
    steps(14);

    // Asynchronous reset in the middle of a run
    s_start = 1'b1; s_len = 4'd10;
    step();
    s_start = 1'b0;
    steps(5);
    rstn = 1'b0;
    #1;
    m_reset();
    chk_all();
    chk("arst_en", 32'(if0.enable), 32'd0);
    step();
    rstn = 1'b1;
    s_start = 1'b1; s_len = 4'd3;
    step();
    s_start = 1'b0;
    steps(10);

    // Randomised traffic
    for (int k = 0; k < 600; k++) begin
      s_start = ($urandom_range(0, 3) == 0);
      s_abort = ($urandom_range(0, 19) == 0);
      s_len   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0)
        s_rep = ~s_rep;
      step();
    end
    s_start = 1'b0; s_abort = 1'b0; s_rep = 1'b0;
    steps(25);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
